// File: rtl/aq_axi_sdma64_pkg.sv
// Shared definitions for the aq_axi_sdma64 control register block.
package aq_axi_sdma64_pkg;

  // Register word indices (byte offset >> 2).
  localparam logic [5:0] RegCtrl    = 6'h00;
  localparam logic [5:0] RegIstat   = 6'h01;
  localparam logic [5:0] RegImask   = 6'h02;
  localparam logic [5:0] RegVersion = 6'h03;
  localparam logic [5:0] RegWrCmd   = 6'h04;
  localparam logic [5:0] RegWrAdrs  = 6'h05;
  localparam logic [5:0] RegWrLen   = 6'h06;
  localparam logic [5:0] RegRdCmd   = 6'h08;
  localparam logic [5:0] RegRdAdrs  = 6'h09;
  localparam logic [5:0] RegRdLen   = 6'h0A;

  // ISTAT bit positions.
  localparam int unsigned IstatWrDone = 0;
  localparam int unsigned IstatRdDone = 1;

  // CTRL bit carrying the soft reset to the engines.
  localparam int unsigned CtrlMasterRst = 31;

  typedef enum logic {WIdle, WResp} wr_state_e;
  typedef enum logic {RIdle, RData} rd_state_e;

  // Merge new_val into old_val, one byte per strobe bit.
  function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[b*8 +: 8] = new_val[b*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/aq_axi_lite_slave.sv
// AXI4-Lite responder: turns bus handshakes into single-cycle register
// write commits and a registered read-data capture.
module aq_axi_lite_slave #(
  parameter int unsigned C_ADDR_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  // Write address / data / response
  input  logic [C_ADDR_WIDTH-1:0] awaddr,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [31:0]             wdata,
  input  logic [3:0]              wstrb,
  input  logic                    wvalid,
  output logic                    wready,
  output logic                    bvalid,
  input  logic                    bready,
  output logic [1:0]              bresp,
  // Read address / data
  input  logic [C_ADDR_WIDTH-1:0] araddr,
  input  logic                    arvalid,
  output logic                    arready,
  output logic [31:0]             rdata,
  output logic [1:0]              rresp,
  output logic                    rvalid,
  input  logic                    rready,
  // Register-file side
  output logic                    wr_en,
  output logic [C_ADDR_WIDTH-1:0] wr_addr,
  output logic [31:0]             wr_data,
  output logic [3:0]              wr_strb,
  output logic                    rd_en,
  output logic [C_ADDR_WIDTH-1:0] rd_addr,
  input  logic [31:0]             rd_data
);
  import aq_axi_sdma64_pkg::*;

  wr_state_e               wr_state_q;
  rd_state_e               rd_state_q;
  logic                    awready_q, wready_q, bvalid_q;
  logic                    aw_held_q, w_held_q;
  logic [C_ADDR_WIDTH-1:0] awaddr_q;
  logic [31:0]             wdata_q;
  logic [3:0]              wstrb_q;
  logic                    arready_q, rvalid_q;
  logic [31:0]             rdata_q;

  // Write FSM: accept AW and W independently, commit once both are held, then respond.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_state_q <= WIdle;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      aw_held_q  <= 1'b0;
      w_held_q   <= 1'b0;
      awaddr_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
    end else begin
      unique case (wr_state_q)
        WIdle: begin
          if (aw_held_q && w_held_q) begin
            // Commit happens this cycle (wr_en); response follows.
            wr_state_q <= WResp;
            bvalid_q   <= 1'b1;
            aw_held_q  <= 1'b0;
            w_held_q   <= 1'b0;
          end else begin
            if (awvalid && awready_q) begin
              awaddr_q  <= awaddr;
              aw_held_q <= 1'b1;
              awready_q <= 1'b0;
            end else if (!aw_held_q) begin
              awready_q <= 1'b1;
            end
            if (wvalid && wready_q) begin
              wdata_q  <= wdata;
              wstrb_q  <= wstrb;
              w_held_q <= 1'b1;
              wready_q <= 1'b0;
            end else if (!w_held_q) begin
              wready_q <= 1'b1;
            end
          end
        end
        WResp: begin
          if (bready) begin
            bvalid_q   <= 1'b0;
            awready_q  <= 1'b1;
            wready_q   <= 1'b1;
            wr_state_q <= WIdle;
          end
        end
        default: wr_state_q <= WIdle;
      endcase
    end
  end

  // Read FSM: capture register data at the address handshake, hold it until RREADY.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_state_q <= RIdle;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
    end else begin
      unique case (rd_state_q)
        RIdle: begin
          if (arvalid && arready_q) begin
            rdata_q    <= rd_data;
            rvalid_q   <= 1'b1;
            arready_q  <= 1'b0;
            rd_state_q <= RData;
          end else begin
            arready_q <= 1'b1;
          end
        end
        RData: begin
          if (rready) begin
            rvalid_q   <= 1'b0;
            arready_q  <= 1'b1;
            rd_state_q <= RIdle;
          end
        end
        default: rd_state_q <= RIdle;
      endcase
    end
  end

  assign awready = awready_q;
  assign wready  = wready_q;
  assign bvalid  = bvalid_q;
  assign bresp   = 2'b00;
  assign arready = arready_q;
  assign rvalid  = rvalid_q;
  assign rdata   = rdata_q;
  assign rresp   = 2'b00;

  assign wr_en   = (wr_state_q == WIdle) && aw_held_q && w_held_q;
  assign wr_addr = awaddr_q;
  assign wr_data = wdata_q;
  assign wr_strb = wstrb_q;

  // Read data is sampled from the live register mux at the AR handshake edge,
  // so a same-cycle write commit is not yet visible.
  assign rd_en   = (rd_state_q == RIdle) && arvalid && arready_q;
  assign rd_addr = araddr;

endmodule

// File: rtl/aq_axi_sdma64_regs.sv
// Control register file for aq_axi_sdma64: decode, DMA start pulses,
// sticky done status and interrupt generation.
module aq_axi_sdma64_regs #(
  parameter int unsigned C_ADDR_WIDTH = 16,
  parameter logic [31:0] C_VERSION    = 32'h0001_0000
) (
  input  logic                    S_AXI_ACLK,
  input  logic                    S_AXI_ARESETN,
  input  logic [C_ADDR_WIDTH-1:0] S_AXI_AWADDR,
  input  logic [3:0]              S_AXI_AWCACHE,
  input  logic [2:0]              S_AXI_AWPROT,
  input  logic                    S_AXI_AWVALID,
  output logic                    S_AXI_AWREADY,
  input  logic [31:0]             S_AXI_WDATA,
  input  logic [3:0]              S_AXI_WSTRB,
  input  logic                    S_AXI_WVALID,
  output logic                    S_AXI_WREADY,
  output logic                    S_AXI_BVALID,
  input  logic                    S_AXI_BREADY,
  output logic [1:0]              S_AXI_BRESP,
  input  logic [C_ADDR_WIDTH-1:0] S_AXI_ARADDR,
  input  logic [3:0]              S_AXI_ARCACHE,
  input  logic [2:0]              S_AXI_ARPROT,
  input  logic                    S_AXI_ARVALID,
  output logic                    S_AXI_ARREADY,
  output logic [31:0]             S_AXI_RDATA,
  output logic [1:0]              S_AXI_RRESP,
  output logic                    S_AXI_RVALID,
  input  logic                    S_AXI_RREADY,
  output logic                    MASTER_RST,
  output logic                    WR_START,
  output logic [31:0]             WR_ADRS,
  output logic [31:0]             WR_LEN,
  input  logic                    WR_BUSY,
  input  logic                    WR_DONE,
  output logic                    RD_START,
  output logic [31:0]             RD_ADRS,
  output logic [31:0]             RD_LEN,
  input  logic                    RD_BUSY,
  input  logic                    RD_DONE,
  output logic                    INTERRUPT
);
  import aq_axi_sdma64_pkg::*;

  logic                    wr_en, rd_en;
  logic [C_ADDR_WIDTH-1:0] wr_addr, rd_addr;
  logic [31:0]             wr_data, rd_data;
  logic [3:0]              wr_strb;
  logic [5:0]              wr_word, rd_word;

  logic        master_rst_q;
  logic [1:0]  istat_q, istat_d, istat_clr;
  logic [3:0]  imask_q;
  logic [31:0] wr_adrs_q, wr_len_q, rd_adrs_q, rd_len_q;
  logic        wr_start_q, rd_start_q, irq_q;

  aq_axi_lite_slave #(
    .C_ADDR_WIDTH(C_ADDR_WIDTH)
  ) u_slave (
    .clk     (S_AXI_ACLK),
    .rst_n   (S_AXI_ARESETN),
    .awaddr  (S_AXI_AWADDR),
    .awvalid (S_AXI_AWVALID),
    .awready (S_AXI_AWREADY),
    .wdata   (S_AXI_WDATA),
    .wstrb   (S_AXI_WSTRB),
    .wvalid  (S_AXI_WVALID),
    .wready  (S_AXI_WREADY),
    .bvalid  (S_AXI_BVALID),
    .bready  (S_AXI_BREADY),
    .bresp   (S_AXI_BRESP),
    .araddr  (S_AXI_ARADDR),
    .arvalid (S_AXI_ARVALID),
    .arready (S_AXI_ARREADY),
    .rdata   (S_AXI_RDATA),
    .rresp   (S_AXI_RRESP),
    .rvalid  (S_AXI_RVALID),
    .rready  (S_AXI_RREADY),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .wr_strb (wr_strb),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  assign wr_word = wr_addr[7:2];
  assign rd_word = rd_addr[7:2];

  // Cache/prot attributes and address bits outside [7:2] carry no meaning here.
  logic unused_sig;
  assign unused_sig = ^{S_AXI_AWCACHE, S_AXI_AWPROT, S_AXI_ARCACHE, S_AXI_ARPROT, rd_en,
                        wr_addr[C_ADDR_WIDTH-1:8], wr_addr[1:0],
                        rd_addr[C_ADDR_WIDTH-1:8], rd_addr[1:0]};

  // Read mux; unmapped words read as zero.
  always_comb begin
    rd_data = '0;
    case (rd_word)
      RegCtrl:    rd_data[CtrlMasterRst] = master_rst_q;
      RegIstat:   rd_data[1:0] = istat_q;
      RegImask:   rd_data[3:0] = imask_q;
      RegVersion: rd_data = C_VERSION;
      RegWrCmd:   rd_data[0] = WR_BUSY;
      RegWrAdrs:  rd_data = wr_adrs_q;
      RegWrLen:   rd_data = wr_len_q;
      RegRdCmd:   rd_data[0] = RD_BUSY;
      RegRdAdrs:  rd_data = rd_adrs_q;
      RegRdLen:   rd_data = rd_len_q;
      default:    rd_data = '0;
    endcase
  end

  // Plain read/write registers with byte-enable merge.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      master_rst_q <= 1'b0;
      imask_q      <= '0;
      wr_adrs_q    <= '0;
      wr_len_q     <= '0;
      rd_adrs_q    <= '0;
      rd_len_q     <= '0;
    end else if (wr_en) begin
      case (wr_word)
        RegCtrl:   if (wr_strb[3]) master_rst_q <= wr_data[CtrlMasterRst];
        RegImask:  if (wr_strb[0]) imask_q <= wr_data[3:0];
        RegWrAdrs: wr_adrs_q <= apply_wstrb(wr_adrs_q, wr_data, wr_strb);
        RegWrLen:  wr_len_q  <= apply_wstrb(wr_len_q, wr_data, wr_strb);
        RegRdAdrs: rd_adrs_q <= apply_wstrb(rd_adrs_q, wr_data, wr_strb);
        RegRdLen:  rd_len_q  <= apply_wstrb(rd_len_q, wr_data, wr_strb);
        default:   ;
      endcase
    end
  end

  // Start pulses: one cycle after an accepted command write; dropped when busy or in soft reset.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      wr_start_q <= 1'b0;
      rd_start_q <= 1'b0;
    end else begin
      wr_start_q <= wr_en && (wr_word == RegWrCmd) && wr_strb[0] && wr_data[0] &&
                    !WR_BUSY && !master_rst_q;
      rd_start_q <= wr_en && (wr_word == RegRdCmd) && wr_strb[0] && wr_data[0] &&
                    !RD_BUSY && !master_rst_q;
    end
  end

  // Sticky status: a DONE pulse wins over a simultaneous W1C of the same bit.
  always_comb begin
    istat_clr = '0;
    if (wr_en && (wr_word == RegIstat) && wr_strb[0]) istat_clr = wr_data[1:0];
    istat_d = (istat_q & ~istat_clr);
    istat_d[IstatWrDone] = istat_d[IstatWrDone] | WR_DONE;
    istat_d[IstatRdDone] = istat_d[IstatRdDone] | RD_DONE;
    if (master_rst_q) istat_d = '0;
  end

  // Status register and registered interrupt level.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      istat_q <= '0;
      irq_q   <= 1'b0;
    end else begin
      istat_q <= istat_d;
      irq_q   <= |(istat_q & imask_q[1:0]);
    end
  end

  assign MASTER_RST = master_rst_q;
  assign WR_START   = wr_start_q;
  assign WR_ADRS    = wr_adrs_q;
  assign WR_LEN     = wr_len_q;
  assign RD_START   = rd_start_q;
  assign RD_ADRS    = rd_adrs_q;
  assign RD_LEN     = rd_len_q;
  assign INTERRUPT  = irq_q;

endmodule

// File: tb/tb_aq_axi_sdma64_regs.sv
// Directed bench for aq_axi_sdma64_regs.
module tb_aq_axi_sdma64_regs;

  logic        clk;
  logic        rst_n;
  logic [15:0] awaddr, araddr;
  logic        awvalid, wvalid, bready, arvalid, rready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        awready, wready, bvalid, arready, rvalid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;
  logic        master_rst, wr_start, rd_start, interrupt;
  logic [31:0] wr_adrs, wr_len, rd_adrs, rd_len;
  logic        wr_busy, wr_done, rd_busy, rd_done;

  int n_checks = 0;
  int n_errors = 0;
  int wr_start_cnt = 0;
  int rd_start_cnt = 0;
  bit aw_ready_bad, b_unstable, r_unstable;
  logic [1:0]  last_bresp;
  logic [31:0] rd_val;
  logic [1:0]  rd_resp;

  aq_axi_sdma64_regs dut (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESETN (rst_n),
    .S_AXI_AWADDR  (awaddr),
    .S_AXI_AWCACHE (4'h3),
    .S_AXI_AWPROT  (3'h0),
    .S_AXI_AWVALID (awvalid),
    .S_AXI_AWREADY (awready),
    .S_AXI_WDATA   (wdata),
    .S_AXI_WSTRB   (wstrb),
    .S_AXI_WVALID  (wvalid),
    .S_AXI_WREADY  (wready),
    .S_AXI_BVALID  (bvalid),
    .S_AXI_BREADY  (bready),
    .S_AXI_BRESP   (bresp),
    .S_AXI_ARADDR  (araddr),
    .S_AXI_ARCACHE (4'h3),
    .S_AXI_ARPROT  (3'h0),
    .S_AXI_ARVALID (arvalid),
    .S_AXI_ARREADY (arready),
    .S_AXI_RDATA   (rdata),
    .S_AXI_RRESP   (rresp),
    .S_AXI_RVALID  (rvalid),
    .S_AXI_RREADY  (rready),
    .MASTER_RST    (master_rst),
    .WR_START      (wr_start),
    .WR_ADRS       (wr_adrs),
    .WR_LEN        (wr_len),
    .WR_BUSY       (wr_busy),
    .WR_DONE       (wr_done),
    .RD_START      (rd_start),
    .RD_ADRS       (rd_adrs),
    .RD_LEN        (rd_len),
    .RD_BUSY       (rd_busy),
    .RD_DONE       (rd_done),
    .INTERRUPT     (interrupt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count cycles in which each start pulse is high.
  always @(negedge clk) begin
    if (wr_start === 1'b1) wr_start_cnt++;
    if (rd_start === 1'b1) rd_start_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic timeout_fail(input string tag);
    n_checks++;
    n_errors++;
    $error("FAIL %s: observed timeout expected handshake", tag);
  endtask

  // Called at a negedge. AW is presented first, W aw_lead cycles later;
  // BREADY is withheld for b_delay cycles once BVALID is seen.
  task automatic axi_write(input logic [15:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int aw_lead, input int b_delay);
    int  c;
    bit  aw_hs, w_hs, aw_done, w_done;
    c = 0; aw_done = 0; w_done = 0; aw_ready_bad = 0; b_unstable = 0;
    awaddr = addr; wdata = data; wstrb = strb; awvalid = 1'b1;
    while (!(aw_done && w_done) && c < 100) begin
      if (c >= aw_lead && !w_done) wvalid = 1'b1;
      if (aw_done && awready) aw_ready_bad = 1;
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      @(negedge clk);
      c++;
      if (aw_hs) begin awvalid = 1'b0; aw_done = 1; end
      if (w_hs)  begin wvalid  = 1'b0; w_done  = 1; end
    end
    if (!(aw_done && w_done)) begin
      timeout_fail("write_addr_data");
      awvalid = 1'b0; wvalid = 1'b0;
    end
    c = 0;
    while (!bvalid && c < 100) begin @(negedge clk); c++; end
    if (!bvalid) timeout_fail("write_bvalid");
    last_bresp = bresp;
    repeat (b_delay) begin
      @(negedge clk);
      if (bvalid !== 1'b1) b_unstable = 1;
    end
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
  endtask

  task automatic axi_read(input logic [15:0] addr, input int r_delay,
                          output logic [31:0] data, output logic [1:0] resp);
    int c;
    bit hs;
    c = 0; r_unstable = 0;
    araddr = addr; arvalid = 1'b1;
    while (arvalid && c < 100) begin
      hs = arvalid && arready;
      @(negedge clk);
      c++;
      if (hs) arvalid = 1'b0;
    end
    if (arvalid) begin timeout_fail("read_addr"); arvalid = 1'b0; end
    c = 0;
    while (!rvalid && c < 100) begin @(negedge clk); c++; end
    if (!rvalid) timeout_fail("read_rvalid");
    data = rdata;
    resp = rresp;
    repeat (r_delay) begin
      @(negedge clk);
      if (rvalid !== 1'b1 || rdata !== data) r_unstable = 1;
    end
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    awaddr = '0; araddr = '0; wdata = '0; wstrb = '0;
    awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
    wr_busy = 0; wr_done = 0; rd_busy = 0; rd_done = 0;

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_awready", {31'b0, awready}, 32'd0);
    check("rst_bvalid", {31'b0, bvalid}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_irq", {31'b0, interrupt}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_awready", {29'b0, awready, wready, arready}, 32'd7);

    // Address / length registers
    axi_write(16'h0014, 32'hFF00_0000, 4'hF, 0, 0);
    check("bresp_adrs", {30'b0, last_bresp}, 32'd0);
    axi_write(16'h0018, 32'h0000_1000, 4'hF, 0, 0);
    axi_read(16'h0014, 0, rd_val, rd_resp);
    check("rd_wr_adrs", rd_val, 32'hFF00_0000);
    check("rresp_adrs", {30'b0, rd_resp}, 32'd0);
    axi_read(16'h0018, 0, rd_val, rd_resp);
    check("rd_wr_len", rd_val, 32'h0000_1000);
    check("port_wr_len", wr_len, 32'h0000_1000);
    axi_read(16'h000C, 0, rd_val, rd_resp);
    check("rd_version", rd_val, 32'h0001_0000);
    axi_write(16'h0024, 32'h8765_4321, 4'hF, 0, 0);
    check("port_rd_adrs", rd_adrs, 32'h8765_4321);

    // Write-DMA start
    axi_write(16'h0010, 32'h1, 4'hF, 0, 0);
    check("wr_start_pulse", wr_start_cnt, 32'd1);
    wr_busy = 1'b1;
    axi_write(16'h0010, 32'h1, 4'hF, 0, 0);
    @(negedge clk);
    check("wr_start_busy", wr_start_cnt, 32'd1);
    axi_read(16'h0010, 0, rd_val, rd_resp);
    check("rd_wr_cmd_busy", rd_val, 32'd1);
    wr_busy = 1'b0;

    // Read-DMA start
    axi_write(16'h0020, 32'h1, 4'hF, 0, 0);
    @(negedge clk);
    check("rd_start_pulse", rd_start_cnt, 32'd1);
    check("wr_start_unchanged", wr_start_cnt, 32'd1);

    // Soft reset blocks starts and holds ISTAT at 0
    axi_write(16'h0000, 32'h8000_0000, 4'hF, 0, 0);
    check("master_rst_on", {31'b0, master_rst}, 32'd1);
    wr_done = 1'b1; @(negedge clk); wr_done = 1'b0;
    axi_write(16'h0010, 32'h1, 4'hF, 0, 0);
    @(negedge clk);
    check("start_in_mrst", wr_start_cnt, 32'd1);
    axi_read(16'h0004, 0, rd_val, rd_resp);
    check("istat_in_mrst", rd_val, 32'd0);
    axi_read(16'h0000, 0, rd_val, rd_resp);
    check("rd_ctrl", rd_val, 32'h8000_0000);
    axi_write(16'h0000, 32'h0, 4'hF, 0, 0);
    check("master_rst_off", {31'b0, master_rst}, 32'd0);

    // Interrupt on RD_DONE, cleared by W1C
    axi_write(16'h0008, 32'hF, 4'hF, 0, 0);
    rd_done = 1'b1;
    @(negedge clk);
    rd_done = 1'b0;
    check("irq_not_yet", {31'b0, interrupt}, 32'd0);
    @(negedge clk);
    check("irq_rd_done", {31'b0, interrupt}, 32'd1);
    axi_read(16'h0004, 0, rd_val, rd_resp);
    check("istat_rd_done", rd_val, 32'd2);
    axi_write(16'h0004, 32'h2, 4'hF, 0, 0);
    @(negedge clk);
    check("irq_cleared", {31'b0, interrupt}, 32'd0);
    axi_read(16'h0004, 0, rd_val, rd_resp);
    check("istat_cleared", rd_val, 32'd0);

    // W1C of bit0 in the same cycle as WR_DONE
    wr_done = 1'b1; @(negedge clk); wr_done = 1'b0;
    axi_write(16'h0008, 32'h0, 4'hF, 0, 0);
    awaddr = 16'h0004; wdata = 32'h1; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0; wr_done = 1'b1;
    @(negedge clk);
    wr_done = 1'b0;
    check("w1c_bvalid", {31'b0, bvalid}, 32'd1);
    bready = 1'b1; @(negedge clk); bready = 1'b0;
    axi_read(16'h0004, 0, rd_val, rd_resp);
    check("w1c_vs_done", rd_val, 32'd1);
    rd_done = 1'b1; @(negedge clk); rd_done = 1'b0;
    repeat (2) @(negedge clk);
    axi_read(16'h0004, 0, rd_val, rd_resp);
    check("istat_both", rd_val, 32'd3);
    check("irq_masked", {31'b0, interrupt}, 32'd0);
    axi_write(16'h0008, 32'h3, 4'hF, 0, 0);
    @(negedge clk);
    check("irq_unmasked", {31'b0, interrupt}, 32'd1);

    // AW ahead of W, slow BREADY, partial strobe
    axi_write(16'h0014, 32'h1234_5678, 4'b0011, 5, 4);
    check("aw_ready_dropped", {31'b0, aw_ready_bad}, 32'd0);
    check("bvalid_stable", {31'b0, b_unstable}, 32'd0);
    check("partial_port", wr_adrs, 32'hFF00_5678);
    axi_read(16'h0014, 2, rd_val, rd_resp);
    check("partial_rd", rd_val, 32'hFF00_5678);
    check("rdata_stable", {31'b0, r_unstable}, 32'd0);

    // Reset in the middle of a write
    awaddr = 16'h0014; wdata = 32'hAAAA_AAAA; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_ready", {29'b0, awready, wready, arready}, 32'd0);
    check("mid_rst_bvalid", {30'b0, bvalid, rvalid}, 32'd0);
    check("mid_rst_irq", {30'b0, interrupt, master_rst}, 32'd0);
    check("mid_rst_adrs", wr_adrs, 32'd0);
    awvalid = 1'b0; wvalid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", {29'b0, awready, wready, arready}, 32'd7);
    check("post_rst_adrs", wr_adrs, 32'd0);

    // Unmapped read ends the run
    axi_read(16'hFFFF, 0, rd_val, rd_resp);
    check("unmapped_rdata", rd_val, 32'd0);
    check("unmapped_rresp", {30'b0, rd_resp}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
